// File: rtl/scsi_port_responder.sv
// Single-channel SCSI DMA port responder: register file, CDREQ_/DACK handshake FSM,
// device-to-host source pop and host-to-device sink push with a 16-bit transfer count.
module scsi_port_responder (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCSI_CS,
    input  logic [1:0] ADDR,
    input  logic       RE,
    input  logic       WE,
    input  logic       DACK,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       CDREQ_,
    output logic       INT,
    input  logic [7:0] SRC_DATA,
    input  logic       SRC_VALID,
    output logic       SRC_POP,
    output logic [7:0] SNK_DATA,
    output logic       SNK_PUSH
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XRD, S_XWR, S_RECOV} state_t;

    state_t      r_state;
    logic        r_dir, r_en, r_done, r_ovr;
    logic [15:0] r_tc;
    logic [7:0]  r_dout, r_wbuf, r_snk_data;
    logic        r_cdreq_n, r_src_pop, r_snk_push;
    logic        r_wr_seen, r_cs_d, r_stat_rd;

    logic        w_reg_wr, w_reg_rd, w_cs_fall, w_busy, w_tc_last;
    logic [15:0] w_tc_dec;
    logic [7:0]  w_status, w_rd_mux;

    assign w_reg_wr  = SCSI_CS & WE & ~r_wr_seen;
    assign w_reg_rd  = SCSI_CS & RE;
    assign w_cs_fall = r_cs_d & ~SCSI_CS;
    assign w_busy    = (r_state != S_IDLE);
    assign w_status  = {5'd0, r_ovr, w_busy, r_done};
    // Count saturates at zero; a zero count can never start a transfer anyway.
    assign w_tc_dec  = (r_tc != 16'd0) ? r_tc - 16'd1 : 16'd0;
    assign w_tc_last = (r_tc == 16'd1);

    always_comb begin
        w_rd_mux = 8'd0;
        case (ADDR)
            2'd0:    w_rd_mux = {6'd0, r_en, r_dir};
            2'd1:    w_rd_mux = r_tc[7:0];
            2'd2:    w_rd_mux = r_tc[15:8];
            default: w_rd_mux = w_status;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_tc       <= 16'd0;
            r_dout     <= 8'd0;
            r_wbuf     <= 8'd0;
            r_snk_data <= 8'd0;
            r_cdreq_n  <= 1'b1;
            r_src_pop  <= 1'b0;
            r_snk_push <= 1'b0;
            r_wr_seen  <= 1'b0;
            r_cs_d     <= 1'b0;
            r_stat_rd  <= 1'b0;
        end else begin
            r_wr_seen  <= SCSI_CS & WE;
            r_cs_d     <= SCSI_CS;
            r_src_pop  <= 1'b0;
            r_snk_push <= 1'b0;

            if (w_reg_rd) begin
                r_dout <= w_rd_mux;
                if (ADDR == 2'd3)
                    r_stat_rd <= 1'b1;
            end
            // Sticky flags clear once the STATUS reader lets go of chip select.
            if (w_cs_fall && r_stat_rd) begin
                r_done    <= 1'b0;
                r_ovr     <= 1'b0;
                r_stat_rd <= 1'b0;
            end
            if (w_reg_wr) begin
                case (ADDR)
                    2'd0: begin
                        r_dir <= DIN[0];
                        r_en  <= DIN[1];
                    end
                    2'd1: if (!w_busy) r_tc[7:0]  <= DIN;
                    2'd2: if (!w_busy) r_tc[15:8] <= DIN;
                    default: ;
                endcase
            end
            if (SCSI_CS && DACK)
                r_ovr <= 1'b1;

            // EN is only consulted in IDLE, so clearing it mid-byte lets that byte finish.
            case (r_state)
                S_IDLE: if (!SCSI_CS) begin
                    if (DACK)
                        r_ovr <= 1'b1;
                    else if (r_en && r_tc != 16'd0 && (!r_dir || SRC_VALID)) begin
                        r_state   <= S_REQ;
                        r_cdreq_n <= 1'b0;
                    end
                end
                S_REQ: if (!SCSI_CS) begin
                    if (DACK && RE && r_dir) begin
                        r_state   <= S_XRD;
                        r_dout    <= SRC_DATA;
                        r_cdreq_n <= 1'b1;
                    end else if (DACK && WE && !r_dir) begin
                        r_state   <= S_XWR;
                        r_wbuf    <= DIN;
                        r_cdreq_n <= 1'b1;
                    end else if (DACK && (RE || WE))
                        r_ovr <= 1'b1;
                    else if (r_dir && !SRC_VALID) begin
                        r_state   <= S_IDLE;
                        r_cdreq_n <= 1'b1;
                    end
                end
                S_XRD: if (!SCSI_CS && !DACK) begin
                    r_src_pop <= 1'b1;
                    r_tc      <= w_tc_dec;
                    r_state   <= S_RECOV;
                    if (w_tc_last) begin
                        r_done <= 1'b1;
                        r_en   <= 1'b0;
                    end
                end
                S_XWR: if (!SCSI_CS) begin
                    if (DACK) begin
                        if (WE)
                            r_wbuf <= DIN;
                    end else begin
                        r_snk_data <= r_wbuf;
                        r_snk_push <= 1'b1;
                        r_tc       <= w_tc_dec;
                        r_state    <= S_RECOV;
                        if (w_tc_last) begin
                            r_done <= 1'b1;
                            r_en   <= 1'b0;
                        end
                    end
                end
                S_RECOV: begin
                    if (DACK && !SCSI_CS)
                        r_ovr <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign DOUT     = r_dout;
    assign CDREQ_   = r_cdreq_n;
    assign INT      = r_done;
    assign SRC_POP  = r_src_pop;
    assign SNK_DATA = r_snk_data;
    assign SNK_PUSH = r_snk_push;
endmodule

// File: doc/scsi_port_responder.md
SCSI_PORT_RESPONDER -- requirements
Module: scsi_port_responder

Interface
REQ-001 The block SHALL have these ports:
- CLK  in  1  sole clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- SCSI_CS  in  1  register chip select, active high
- ADDR  in  2  register select while SCSI_CS is high
- RE  in  1  read strobe from the DMA engine, active high
- WE  in  1  write strobe from the DMA engine, active high
- DACK  in  1  DMA acknowledge, active high
- DIN  in  8  byte written by the DMA engine
- DOUT  out  8  byte returned to the DMA engine
- CDREQ_  out  1  DMA data request, active low
- INT  out  1  transfer-complete interrupt, active high
- SRC_DATA  in  8  next device-to-host byte
- SRC_VALID  in  1  SRC_DATA is valid
- SRC_POP  out  1  one-cycle pulse; SRC_DATA consumed
- SNK_DATA  out  8  host-to-device byte
- SNK_PUSH  out  1  one-cycle pulse; SNK_DATA valid

Function
REQ-002 Register map: 0 CTRL (bit0 DIR, 1 = device-to-host; bit1 EN); 1 TCL; 2 TCH; 3 STATUS (bit0 DONE, bit1 BUSY, bit2 OVR; read-only).
REQ-003 Register write: SHALL occur once, on the first cycle of SCSI_CS&WE, using an edge detect.
REQ-004 Register read: while SCSI_CS&RE, DOUT SHALL present the selected register from the cycle after the strobe is first seen.
REQ-005 STATUS read: SHALL clear DONE and OVR on the cycle SCSI_CS deasserts.
REQ-006 TC = {TCH,TCL}. TC is 16-bit and decrements by 1 per completed byte. TC SHALL NOT wrap below 0.
REQ-007 The FSM SHALL have the states IDLE, REQ, XRD, XWR and RECOV.
REQ-008 IDLE->REQ when EN & TC!=0 & ~SCSI_CS & (DIR ? SRC_VALID : 1). CDREQ_ SHALL be 0 only in REQ.
REQ-009 REQ->XRD when DACK&RE&DIR. REQ->XWR when DACK&WE&~DIR. CDREQ_ SHALL go high on the same clock edge as the transition.
REQ-010 XRD:
- DOUT = SRC_DATA latched on entry and held while DACK.
- On the first cycle DACK=0: pulse SRC_POP, decrement TC, go to RECOV.
REQ-011 XWR:
- DIN SHALL be captured every cycle DACK&WE.
- On the first cycle DACK=0: SNK_DATA = last captured byte, pulse SNK_PUSH, decrement TC, go to RECOV.
REQ-012 RECOV SHALL last exactly 1 cycle, then go to IDLE. Minimum CDREQ_ high time between bytes is 2 cycles.
REQ-013 Completion: when TC reaches 0, the block SHALL set DONE and clear EN. INT = DONE.
REQ-014 BUSY SHALL be 1 in every state except IDLE.
REQ-015 DACK asserted in IDLE or RECOV, or with a mismatched direction strobe in REQ: set OVR, no byte transferred, state unchanged.
REQ-016 SCSI_CS together with DACK: the register access SHALL win, DACK is ignored, and OVR is set.
REQ-017 A write of EN=0 during XRD/XWR SHALL take effect only after RECOV. The in-flight byte completes and is counted.
REQ-018 A TC write while BUSY SHALL be ignored.
REQ-019 SRC_VALID falling while in REQ: SHALL return to IDLE and release CDREQ_ the next cycle.

Reset
REQ-020 On RESET the block SHALL force:
- state IDLE, all registers 0
- CDREQ_=1, DOUT=0, INT=0, SRC_POP=0, SNK_PUSH=0, SNK_DATA=0
REQ-021 RESET asserted mid-transfer SHALL abort the transfer without any SRC_POP or SNK_PUSH pulse.

Verification
REQ-022 Scenario 1: TC=3, DIR=1, EN=1, SRC_DATA 0xA1/0xB2/0xC3. Per byte: 3-cycle DACK&RE handshake -> DOUT matches the byte; 3 SRC_POP pulses; DONE=1, INT=1, TC=0.
REQ-023 Scenario 2: TC=2, DIR=0, DIN 0x5A then 0x3C, WE and DACK dropped together -> SNK_PUSH twice with 0x5A, 0x3C; CDREQ_ high ≥2 cycles between bytes.
REQ-024 Scenario 3: DACK pulse while CDREQ_=1 -> OVR=1, TC unchanged; STATUS read returns 0x04, then reads 0x00.
REQ-025 Scenario 4: RESET during XWR with DACK high -> no SNK_PUSH, CDREQ_=1, TC=0 immediately.
REQ-026 Scenario 5: TC=1, DIR=1, SRC_VALID=0 -> CDREQ_ stays 1. Raise SRC_VALID -> CDREQ_=0 one cycle later.
REQ-027 Scenario 6: TC write 0x0010 while BUSY -> TC value unchanged.
